// File: rtl/fb_vin_packer_if.sv
// fb_vin_packer_if: video-in pixel stream, frame-buffer write stream and status of the packer.
interface fb_vin_packer_if;
    logic        vin_vsync;
    logic        vin_de;
    logic [15:0] vin_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        buf_sel;
    logic        frame_done;
    logic [11:0] line_cnt;
    logic        overflow;
    logic        short_frame;
    modport master (
        input  vin_vsync, vin_de, vin_data, wr_ready,
        output wr_valid, wr_addr, wr_data, buf_sel, frame_done, line_cnt, overflow, short_frame
    );
    modport slave (
        output vin_vsync, vin_de, vin_data, wr_ready,
        input  wr_valid, wr_addr, wr_data, buf_sel, frame_done, line_cnt, overflow, short_frame
    );
endinterface

// File: rtl/fb_vin_packer.sv
// fb_vin_packer: packs RGB565 pixel pairs into address-tagged words, queues them in a FWFT FIFO
// and ping-pongs between two frame buffers.
module fb_vin_packer #(
    parameter logic [31:0] BASE_ADDR0 = 32'h8000_0000,
    parameter logic [31:0] BASE_ADDR1 = 32'h8020_0000,
    parameter int          H_RES      = 1280,
    parameter int          V_RES      = 720,
    parameter int          FIFO_DEPTH = 16,
    parameter bit          VS_POL     = 1'b1
) (
    input logic clk,
    input logic rst,
    fb_vin_packer_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] WORDS = 32'(H_RES * V_RES / 2);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
    state_t state;
    logic vs_q, de_q, half, push_pend, buf_sel, frame_done, overflow, short_frame;
    logic [15:0] pix0;
    logic [11:0] line_cnt;
    logic [31:0] addr_ptr, push_cnt, push_addr, push_data;
    logic [31:0] mem_addr [FIFO_DEPTH];
    logic [31:0] mem_data [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic vs_start, de_fall, empty, full, pop, wr_en, take;
    assign vs_start = (bus.vin_vsync == VS_POL) && (vs_q != VS_POL);
    assign de_fall  = de_q && !bus.vin_de;
    assign empty    = wptr == rptr;
    assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign pop      = !empty && bus.wr_ready;
    // a full FIFO still accepts the word when the head leaves in the same cycle
    assign wr_en    = push_pend && (!full || pop);
    assign take     = state == CAPTURE && !vs_start && push_cnt != WORDS && bus.vin_de;
    assign bus.wr_valid    = !empty;
    assign bus.wr_addr     = empty ? '0 : mem_addr[rptr[AW-1:0]];
    assign bus.wr_data     = empty ? '0 : mem_data[rptr[AW-1:0]];
    assign bus.buf_sel     = buf_sel;
    assign bus.frame_done  = frame_done;
    assign bus.line_cnt    = line_cnt;
    assign bus.overflow    = overflow;
    assign bus.short_frame = short_frame;
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_addr[wptr[AW-1:0]] <= push_addr;
            mem_data[wptr[AW-1:0]] <= push_data;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            vs_q        <= VS_POL;
            de_q        <= 1'b0;
            half        <= 1'b0;
            push_pend   <= 1'b0;
            pix0        <= '0;
            push_addr   <= '0;
            push_data   <= '0;
            addr_ptr    <= '0;
            push_cnt    <= '0;
            wptr        <= '0;
            rptr        <= '0;
            buf_sel     <= 1'b0;
            frame_done  <= 1'b0;
            line_cnt    <= '0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            vs_q       <= bus.vin_vsync;
            de_q       <= bus.vin_de;
            push_pend  <= take && half;
            frame_done <= 1'b0;
            if (take && half) begin
                push_data <= {bus.vin_data, pix0};
                push_addr <= addr_ptr;
                addr_ptr  <= addr_ptr + 32'd4;
                push_cnt  <= push_cnt + 32'd1;
                half      <= 1'b0;
            end else if (take) begin
                pix0 <= bus.vin_data;
                half <= 1'b1;
            end
            if (wr_en) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (push_pend && full && !pop) overflow <= 1'b1;
            case (state)
                IDLE, CAPTURE: begin
                    if (vs_start) begin
                        state    <= CAPTURE;
                        addr_ptr <= buf_sel ? BASE_ADDR1 : BASE_ADDR0;
                        push_cnt <= '0;
                        line_cnt <= '0;
                        half     <= 1'b0;
                        if (state == CAPTURE) short_frame <= 1'b1;
                    end else if (state == CAPTURE) begin
                        if (de_fall) begin
                            line_cnt <= line_cnt + 12'd1;
                            half     <= 1'b0;
                        end
                        if (push_cnt == WORDS) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty && !push_pend) begin
                        frame_done <= 1'b1;
                        buf_sel    <= !buf_sel;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_vin_packer.sv
// tb_fb_vin_packer: directed checks of two packers (FIFO depth 4 and 2) sharing one pixel stream.
module tb_fb_vin_packer;
    typedef struct {
        logic [15:0] p0;
        logic [15:0] p1;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0, rst = 1'b0, vs = 1'b0, de = 1'b0, rdy0 = 1'b1, rdy1 = 1'b1;
    logic [15:0] pix = '0;
    int n_cmp = 0, n_bad = 0, done0 = 0, done1 = 0;
    logic [63:0] got0[$];
    logic [63:0] got1[$];
    vec_t v[8];
    ent_t t4[6] = '{'{32'h8000_0000, 32'h0002_0001}, '{32'h8000_0004, 32'h0004_0003},
                    '{32'h8000_0000, 32'h0012_0011}, '{32'h8000_0004, 32'h0014_0013},
                    '{32'h8000_0008, 32'h0016_0015}, '{32'h8000_000C, 32'h0018_0017}};
    ent_t t5[4] = '{'{32'h8000_0000, 32'h0022_0021}, '{32'h8000_0004, 32'h0032_0031},
                    '{32'h8000_0008, 32'h0034_0033}, '{32'h8000_000C, 32'h0042_0041}};

    always #5 clk = ~clk;

    fb_vin_packer_if i0 ();
    fb_vin_packer_if i1 ();
    assign i0.vin_vsync = vs;
    assign i0.vin_de    = de;
    assign i0.vin_data  = pix;
    assign i0.wr_ready  = rdy0;
    assign i1.vin_vsync = vs;
    assign i1.vin_de    = de;
    assign i1.vin_data  = pix;
    assign i1.wr_ready  = rdy1;

    fb_vin_packer #(.H_RES(4), .V_RES(2), .FIFO_DEPTH(4)) u0 (.clk(clk), .rst(rst), .bus(i0));
    fb_vin_packer #(.H_RES(4), .V_RES(2), .FIFO_DEPTH(2)) u1 (.clk(clk), .rst(rst), .bus(i1));

    always @(negedge clk) begin
        if (i0.wr_valid && i0.wr_ready) got0.push_back({i0.wr_addr, i0.wr_data});
        if (i1.wr_valid && i1.wr_ready) got1.push_back({i1.wr_addr, i1.wr_data});
        if (i0.frame_done) done0++;
        if (i1.frame_done) done1++;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; vs = 1'b0; de = 1'b0; pix = '0;
        tick(2);
        rst = 1'b0;
        tick();
    endtask

    task automatic send_vs();
        vs = 1'b1; tick();
        vs = 1'b0; tick();
    endtask

    task automatic send_line(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            de = 1'b1; pix = first + 16'(i); tick();
        end
        de = 1'b0; pix = '0;
        tick(2);
    endtask

    task automatic wait_for(input int which, input int target);
        int k;
        k = 0;
        while (((which == 0) ? done0 : done1) < target && k < 50) begin
            tick();
            k++;
        end
        chk($sformatf("frame_done%0d reached", which), 64'((which == 0) ? done0 : done1), 64'(target));
    endtask

    initial begin
        int b0, b1, d0, d1;
        for (int i = 0; i < 8; i++) begin
            v[i].p0   = 16'(2 * (i % 4) + 1);
            v[i].p1   = 16'(2 * (i % 4) + 2);
            v[i].addr = ((i < 4) ? 32'h8000_0000 : 32'h8020_0000) + 32'(4 * (i % 4));
            v[i].data = {v[i].p1, v[i].p0};
        end

        do_reset();
        chk("rst wr_valid", 64'(i0.wr_valid), 64'd0);
        chk("rst wr_addr", 64'(i0.wr_addr), 64'd0);
        chk("rst wr_data", 64'(i0.wr_data), 64'd0);
        chk("rst buf_sel", 64'(i0.buf_sel), 64'd0);
        chk("rst line_cnt", 64'(i0.line_cnt), 64'd0);
        chk("rst flags", 64'({i0.overflow, i0.short_frame, i0.frame_done}), 64'd0);

        // two full frames, ping-pong addressing
        b0 = got0.size(); d0 = done0;
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 0) send_vs();
            de = 1'b1; pix = v[i].p0; tick();
            pix = v[i].p1; tick();
            if (i % 2 == 1) begin
                de = 1'b0; pix = '0; tick(2);
            end
            if (i % 4 == 3) begin
                wait_for(0, d0 + i / 4 + 1);
                chk("frame buf_sel", 64'(i0.buf_sel), (i < 4) ? 64'd1 : 64'd0);
                chk("frame line_cnt", 64'(i0.line_cnt), 64'd2);
            end
        end
        tick(3);
        chk("frame_done count", 64'(done0 - d0), 64'd2);
        chk("frame entries", 64'(got0.size() - b0), 64'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("frame entry %0d", i), got0[b0 + i], {v[i].addr, v[i].data});

        // overflow with consumer stalled on the depth-2 packer
        do_reset();
        rdy1 = 1'b0; b1 = got1.size(); d1 = done1;
        send_vs();
        send_line(16'h0001, 4);
        send_line(16'h0005, 4);
        tick(3);
        chk("ovf overflow", 64'(i1.overflow), 64'd1);
        chk("ovf head", {i1.wr_addr, i1.wr_data}, {32'h8000_0000, 32'h0002_0001});
        tick(4);
        chk("ovf head stable", {i1.wr_valid, i1.wr_addr, i1.wr_data}, {1'b1, 32'h8000_0000, 32'h0002_0001});
        chk("ovf no done yet", 64'(done1 - d1), 64'd0);
        rdy1 = 1'b1;
        wait_for(1, d1 + 1);
        chk("ovf drained", 64'(got1.size() - b1), 64'd2);
        chk("ovf last kept", got1[got1.size() - 1], {32'h8000_0004, 32'h0004_0003});
        chk("ovf buf_sel", 64'(i1.buf_sel), 64'd1);

        // odd-length line discards the lone pixel
        do_reset();
        b0 = got0.size(); d0 = done0;
        send_vs();
        send_line(16'h0021, 3);
        send_line(16'h0031, 4);
        send_line(16'h0041, 2);
        wait_for(0, d0 + 1);
        chk("odd line_cnt", 64'(i0.line_cnt), 64'd3);
        chk("odd entries", 64'(got0.size() - b0), 64'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("odd entry %0d", i), got0[b0 + i], {t5[i].addr, t5[i].data});

        // early vsync aborts the frame; stale entries still drain
        do_reset();
        rdy0 = 1'b0; b0 = got0.size(); d0 = done0;
        send_vs();
        send_line(16'h0001, 4);
        chk("short held", 64'(i0.wr_valid), 64'd1);
        send_vs();
        chk("short flag", 64'(i0.short_frame), 64'd1);
        chk("short buf_sel", 64'(i0.buf_sel), 64'd0);
        chk("short no done", 64'(done0 - d0), 64'd0);
        rdy0 = 1'b1;
        send_line(16'h0011, 4);
        send_line(16'h0015, 4);
        wait_for(0, d0 + 1);
        chk("short entries", 64'(got0.size() - b0), 64'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("short entry %0d", i), got0[b0 + i], {t4[i].addr, t4[i].data});
        chk("short buf_sel after", 64'(i0.buf_sel), 64'd1);

        // reset in the middle of a capture with entries queued
        rdy0 = 1'b0;
        send_vs();
        send_line(16'h0001, 4);
        chk("mid head", {i0.wr_valid, i0.wr_addr}, {1'b1, 32'h8020_0000});
        chk("mid line_cnt", 64'(i0.line_cnt), 64'd1);
        rst = 1'b1;
        tick();
        chk("mid rst valid/addr", {i0.wr_valid, i0.wr_addr, i0.wr_data}, 65'd0);
        chk("mid rst flags", 64'({i0.overflow, i0.short_frame, i0.buf_sel}), 64'd0);
        chk("mid rst line_cnt", 64'(i0.line_cnt), 64'd0);
        rst = 1'b0;
        rdy0 = 1'b1;
        tick();
        send_line(16'h0001, 4);
        tick(2);
        chk("idle ignores pixels", 64'({i0.wr_valid, i0.line_cnt}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
